prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 37 +++
 rtl/prog_loader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// -----------------------------------------------------------------------------
// prog_loader_if
// Groups the host byte-stream handshake, the instruction-memory write port and
// the core control/status lines of the program loader.
//
//   in_valid, in_data[7:0]      host -> loader byte stream
//   in_ready                    loader -> host, byte accepted when both high
//   reload                      one-cycle restart request from DONE/ERR
//   imem_we, imem_addr[31:0],
//   imem_wdata[31:0]            instruction-memory write port
//   core_rst                    held high until a program is loaded
//   done, error                 load status
//
// master: the host/system side; slave: the loader.
// -----------------------------------------------------------------------------
interface prog_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    modport master (
        output in_valid, in_data, reload,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
    );

    modport slave (
        input  in_valid, in_data, reload,
        output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Receives a program over a little-endian byte stream
//   [length N] [N instruction words] [checksum word]
// writes each instruction word to instruction memory starting at BASE_ADDR,
// and releases the core from reset once the checksum matches the 32-bit
// wrapping sum of the instruction words.
//
// Ports:
//   CLK   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   prog_loader_if.slave (byte stream, imem write port, status)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         rst,
    prog_loader_if.slave bus
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {HDR, LOAD, CSUM, DONE, ERR} state_t;

    state_t             r_state;
    logic [1:0]         r_byte_cnt;
    logic [23:0]        r_buf;        // first three bytes of the word in flight
    logic [IDX_W-1:0]   r_len;
    logic [IDX_W-1:0]   r_word_idx;
    logic [31:0]        r_csum;
    logic               r_in_ready;
    logic               r_imem_we;
    logic [31:0]        r_imem_addr;
    logic [31:0]        r_imem_wdata;
    logic               r_core_rst;
    logic               r_done;
    logic               r_error;

    logic               w_xfer;
    logic               w_last_byte;
    logic [31:0]        w_word;

    assign w_xfer      = bus.in_valid && r_in_ready;
    assign w_last_byte = w_xfer && (r_byte_cnt == 2'd3);
    // The 4th byte is the most significant; it completes the word combinationally
    // so the decision for that word is taken on the very edge that accepts it.
    assign w_word      = {bus.in_data, r_buf};

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the reset branch is asynchronous and covers every register.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state      <= HDR;
            r_byte_cnt   <= 2'd0;
            r_buf        <= 24'd0;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_csum       <= 32'd0;
            r_in_ready   <= 1'b1;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= BASE_ADDR;
            r_imem_wdata <= 32'd0;
            r_core_rst   <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse; address/data simply hold.
            r_imem_we <= 1'b0;

            if (w_xfer) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;   // wraps 3 -> 0 on word completion
                case (r_byte_cnt)
                    2'd0:    r_buf[7:0]   <= bus.in_data;
                    2'd1:    r_buf[15:8]  <= bus.in_data;
                    2'd2:    r_buf[23:16] <= bus.in_data;
                    default: ;
                endcase
            end

            if (w_last_byte) begin
                case (r_state)
                    HDR: begin
                        if (w_word > 32'(MAX_WORDS)) begin
                            r_state    <= ERR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_word == 32'd0) begin
                            r_state <= CSUM;
                        end else begin
                            r_state    <= LOAD;
                            r_len      <= w_word[IDX_W-1:0];
                            r_word_idx <= '0;
                        end
                    end
                    LOAD: begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= BASE_ADDR + (32'(r_word_idx) << 2);
                        r_imem_wdata <= w_word;
                        r_csum       <= r_csum + w_word;
                        if (r_word_idx == r_len - IDX_W'(1)) begin
                            r_state <= CSUM;
                        end else begin
                            r_word_idx <= r_word_idx + IDX_W'(1);
                        end
                    end
                    CSUM: begin
                        r_in_ready <= 1'b0;
                        if (w_word == r_csum) begin
                            r_state    <= DONE;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Terminal states accept no bytes, so reload never races a transfer.
            if (bus.reload && (r_state == DONE || r_state == ERR)) begin
                r_state    <= HDR;
                r_byte_cnt <= 2'd0;
                r_word_idx <= '0;
                r_csum     <= 32'd0;
                r_in_ready <= 1'b1;
                r_core_rst <= 1'b1;
                r_done     <= 1'b0;
                r_error    <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.core_rst   = r_core_rst;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

endmodule
